eig_seq_ctrl: RTL and testbench
===============================

# eig_seq_ctrl

Sequencer for the eigenvalue pipeline. It accepts a "parameters loaded" pulse from the parameter loader and issues a one-cycle start to the eigen core. It then waits for the core's result-valid pulse and issues a start to the output loader, tracking that loader's busy handshake until the output is done. Every wait is guarded by a watchdog timeout that aborts the run and flags an error, so a hung core or loader cannot stall the chip.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1023: maximum number of cycles spent in any wait state. Legal range is 2..65535.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the timeout counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable. Low freezes the FSM, the counter and all flags, and forces the start/done pulses to 0.
- load_done  in  1  1-cycle pulse: a0/a1 are valid at the core inputs
- core_start  out  1  1-cycle start pulse to the eigen core
- core_valid  in  1  1-cycle pulse: kappa/inv_kappa/regime are valid
- ol_start  out  1  1-cycle start pulse to the output loader
- ol_busy  in  1  output loader busy level
- seq_busy  out  1  high in every state except IDLE; back-pressures the parameter loader
- done  out  1  1-cycle pulse: run completed normally
- err  out  1  sticky timeout flag
- err_code  out  2  cause of the last abort: 01 core, 10 ol ack, 11 ol finish
- ovf  out  1  sticky flag: a load_done was dropped
- err_clr  in  1  synchronous clear of err, err_code and ovf
- run_cnt  out  8  completed-run counter, wraps 255->0
- state_o  out  3  state encoding, for debug

## Operation
- Outputs are Moore-decoded from the registered state. done, err_code, ovf and run_cnt are registered.
- State encodings:
  - IDLE = 0
  - CORE_ISSUE = 1
  - CORE_WAIT = 2
  - OL_ISSUE = 3
  - OL_ACK = 4
  - OL_WAIT = 5
  - ABORT = 6
- State transitions:
  - IDLE: load_done -> CORE_ISSUE.
  - CORE_ISSUE: core_start=1 -> CORE_WAIT; counter cleared.
  - CORE_WAIT: core_valid -> OL_ISSUE. Otherwise timeout -> ABORT with code 01.
  - OL_ISSUE: ol_start=1 -> OL_ACK; counter cleared.
  - OL_ACK: ol_busy=1 -> OL_WAIT, counter cleared. Otherwise timeout -> ABORT with code 10.
  - OL_WAIT: ol_busy=0 -> IDLE, with done pulsed and run_cnt incremented. Otherwise timeout -> ABORT with code 11.
  - ABORT: one cycle. err set, err_code latched -> IDLE. No done pulse, no run_cnt increment.
- Timeout counter:
  - Starts at 0 in the first cycle of a wait state and increments each cycle.
  - Timeout fires when counter == TIMEOUT_CYCLES-1 and the awaited event is absent.
  - If the event and the timeout coincide, the event wins.
- load_done while not in IDLE is handled per the Configuration section.
- err_clr has priority over a simultaneous ABORT set: the flag is cleared and the new abort is lost. err_clr does not change the state.
- Reset values:
  - state IDLE
  - all outputs 0
  - counter 0
  - run_cnt 0
  - pending flag 0

## Timing
- load_done sampled at edge N -> core_start high during cycle N+1.
- core_valid sampled at edge M -> ol_start high during cycle M+1.
- ol_busy falling edge seen at edge P -> done high during cycle P+1, with run_cnt updated in the same cycle.
- Minimum run length from load_done to done is 5 cycles. Successive runs need a minimum of 1 IDLE cycle between them.
- Reset asserted mid-run: immediate return to IDLE. Any start pulse in flight is cut; there is no partial done.
- ena low for K cycles stretches all latencies by exactly K. It does not count toward the timeout.

## Configuration
- EIGSEQ_PENDING_EN defined:
  - A one-deep pending buffer captures a load_done that arrives while seq_busy is high.
  - On return to IDLE with the buffer set, the FSM goes directly to CORE_ISSUE in the next cycle, and the buffer clears.
  - ovf is set only when a load_done arrives while the buffer is already full.
- EIGSEQ_PENDING_EN undefined:
  - A load_done arriving while seq_busy is high is dropped and sets ovf.

## Test plan
- Nominal run, TIMEOUT_CYCLES=16: load_done, core_valid after 3 cycles, ol_busy high for 8 cycles -> core_start, ol_start and done each pulse exactly once, run_cnt=1, err=0.
- Core hang: no core_valid -> ABORT after 16 cycles in CORE_WAIT, err=1, err_code=01, state back to IDLE, run_cnt unchanged.
- Loader never goes busy -> err_code=10. Loader stuck busy -> err_code=11. err_clr then clears err, err_code and ovf to 0.
- core_valid on the last timeout cycle (counter=15) -> proceeds to OL_ISSUE with no error.
- Second load_done during CORE_WAIT:
  - With EIGSEQ_PENDING_EN: two done pulses, ovf=0.
  - Without it: one done pulse, ovf=1.
  - A third load_done with the macro defined sets ovf=1.
- ena dropped for 5 cycles in CORE_WAIT and rst_n pulsed mid-OL_WAIT:
  - The ena run completes 5 cycles later with no timeout.
  - The reset returns every output to 0 and the state to IDLE within the same cycle.

Source files
------------

// File: rtl/eig_seq_ctrl.sv
// Eigenvalue pipeline sequencer: load -> core -> output loader, with watchdog.
// Optional one-deep pending load buffer: define EIGSEQ_PENDING_EN.
module eig_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       load_done,
  output logic       core_start,
  input  logic       core_valid,
  output logic       ol_start,
  input  logic       ol_busy,
  output logic       seq_busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       ovf,
  input  logic       err_clr,
  output logic [7:0] run_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CORE_ISSUE = 3'd1,
    S_CORE_WAIT  = 3'd2,
    S_OL_ISSUE   = 3'd3,
    S_OL_ACK     = 3'd4,
    S_OL_WAIT    = 3'd5,
    S_ABORT      = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             done_q, done_d;
  logic             err_q;
  logic [1:0]       err_code_q;
  logic             ovf_q;
  logic [7:0]       run_cnt_q;
  logic             pend_q;
  logic             ovf_set;
  logic             tmo;

  assign tmo = (cnt_q == TO_LAST);

  // Next-state, watchdog counter and abort cause
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q || load_done) state_d = S_CORE_ISSUE;
      end
      S_CORE_ISSUE: begin
        state_d = S_CORE_WAIT;
        cnt_d   = '0;
      end
      S_CORE_WAIT: begin
        if (core_valid) begin
          state_d = S_OL_ISSUE;
        end else if (tmo) begin
          state_d = S_ABORT;
          cause_d = 2'b01;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OL_ISSUE: begin
        state_d = S_OL_ACK;
        cnt_d   = '0;
      end
      S_OL_ACK: begin
        if (ol_busy) begin
          state_d = S_OL_WAIT;
          cnt_d   = '0;
        end else if (tmo) begin
          state_d = S_ABORT;
          cause_d = 2'b10;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OL_WAIT: begin
        if (!ol_busy) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tmo) begin
          state_d = S_ABORT;
          cause_d = 2'b11;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef EIGSEQ_PENDING_EN
  logic pend_d;

  // Pending buffer: absorb one load while busy, overflow on a second
  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (state_q == S_IDLE) begin
      pend_d = pend_q & load_done;
    end else if (load_done) begin
      if (pend_q) ovf_set = 1'b1;
      else        pend_d  = 1'b1;
    end
  end

  // Pending buffer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pend_q <= 1'b0;
    else if (ena) pend_q <= pend_d;
  end
`else
  assign pend_q  = 1'b0;
  assign ovf_set = load_done && (state_q != S_IDLE);
`endif

  // State, counter, pulses and sticky flags; ena low freezes all of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cause_q    <= 2'b00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      ovf_q      <= 1'b0;
      run_cnt_q  <= 8'd0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      done_q  <= done_d;
      if (done_d) run_cnt_q <= run_cnt_q + 8'd1;
      if (err_clr) begin
        err_q      <= 1'b0;
        err_code_q <= 2'b00;
        ovf_q      <= 1'b0;
      end else begin
        if (state_q == S_ABORT) begin
          err_q      <= 1'b1;
          err_code_q <= cause_q;
        end
        if (ovf_set) ovf_q <= 1'b1;
      end
    end
  end

  assign core_start = ena && (state_q == S_CORE_ISSUE);
  assign ol_start   = ena && (state_q == S_OL_ISSUE);
  assign seq_busy   = (state_q != S_IDLE);
  assign done       = ena && done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign ovf        = ovf_q;
  assign run_cnt    = run_cnt_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_eig_seq_ctrl.sv
// Testbench for eig_seq_ctrl: table-driven runs with a done-time scoreboard,
// plus a hand-written mid-run reset sequence.
module tb_eig_seq_ctrl;

  localparam int T = 16;
`ifdef EIGSEQ_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif
  localparam int NR = PEND ? 2 : 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       load_done = 1'b0;
  logic       core_start;
  logic       core_valid = 1'b0;
  logic       ol_start;
  logic       ol_busy = 1'b0;
  logic       seq_busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       ovf;
  logic       err_clr = 1'b0;
  logic [7:0] run_cnt;
  logic [2:0] state_o;

  eig_seq_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .load_done(load_done), .core_start(core_start),
    .core_valid(core_valid), .ol_start(ol_start),
    .ol_busy(ol_busy), .seq_busy(seq_busy), .done(done),
    .err(err), .err_code(err_code), .ovf(ovf),
    .err_clr(err_clr), .run_cnt(run_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c; int a; int b;
    int ld2; int ld3;
    int en_at; int en_len;
    bit clr_ab;
    int n_cs; int n_os; int n_done;
    bit e_err; logic [1:0] e_code; bit e_ovf;
    int e_errcyc;
  } vec_t;

  vec_t tbl[11];
  int   exp_q[$];
  int   total = 0;
  int   bad = 0;
  logic [7:0] rc = 8'd0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int st, wc, ac, busy_left, cs_n, os_n, dn_n, err_first, d1, e;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk($sformatf("v%0d clr_err", k), int'(err), 0);
    chk($sformatf("v%0d clr_code", k), int'(err_code), 0);
    chk($sformatf("v%0d clr_ovf", k), int'(ovf), 0);
    st = int'(state_o);
    wc = 0; ac = 0; busy_left = 0;
    cs_n = 0; os_n = 0; dn_n = 0; err_first = -1;
    d1 = 4 + v.c + v.a + v.b + v.en_len;
    if (v.n_done >= 1) exp_q.push_back(d1);
    if (v.n_done >= 2) exp_q.push_back(d1 + 1 + 4 + v.c + v.a + v.b);
    for (int i = 0; i < 40; i++) begin
      ena = !(v.en_at >= 0 && i >= v.en_at && i < v.en_at + v.en_len);
      load_done = (i == 0) || (i == v.ld2) || (i == v.ld3);
      core_valid = 1'b0;
      err_clr = v.clr_ab && (st == 6);
      if (ena) begin
        if (st == 2) begin
          if (wc == v.c) core_valid = 1'b1;
          wc++;
        end else wc = 0;
        if (st == 4) begin
          if (ac == v.a) busy_left = (v.b < 0) ? 1000 : v.b;
          ac++;
        end else ac = 0;
      end
      ol_busy = (busy_left > 0);
      if (ena && busy_left > 0) busy_left--;
      tick();
      st = int'(state_o);
      cs_n += int'(core_start);
      os_n += int'(ol_start);
      if (err && err_first < 0) err_first = i;
      if (done) begin
        dn_n++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL v%0d done_extra: got done at %0d want none", k, i);
        end else begin
          e = exp_q.pop_front();
          if (e != i) begin
            bad++;
            $display("FAIL v%0d done_time: got %0d want %0d", k, i, e);
          end
        end
      end
    end
    load_done = 1'b0; core_valid = 1'b0; ol_busy = 1'b0;
    ena = 1'b1; err_clr = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; bad++;
      $display("FAIL v%0d done_missing: got none want done at %0d", k, e);
    end
    rc = rc + 8'(v.n_done);
    chk($sformatf("v%0d core_start_n", k), cs_n, v.n_cs);
    chk($sformatf("v%0d ol_start_n", k), os_n, v.n_os);
    chk($sformatf("v%0d done_n", k), dn_n, v.n_done);
    chk($sformatf("v%0d err", k), int'(err), int'(v.e_err));
    chk($sformatf("v%0d err_code", k), int'(err_code), int'(v.e_code));
    chk($sformatf("v%0d ovf", k), int'(ovf), int'(v.e_ovf));
    chk($sformatf("v%0d run_cnt", k), int'(run_cnt), int'(rc));
    chk($sformatf("v%0d state_end", k), int'(state_o), 0);
    if (v.e_err) chk($sformatf("v%0d err_cycle", k), err_first, v.e_errcyc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " core_start"}, int'(core_start), 0);
    chk({tag, " ol_start"}, int'(ol_start), 0);
    chk({tag, " seq_busy"}, int'(seq_busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " err"}, int'(err), 0);
    chk({tag, " err_code"}, int'(err_code), 0);
    chk({tag, " ovf"}, int'(ovf), 0);
    chk({tag, " run_cnt"}, int'(run_cnt), int'(rc));
    chk({tag, " state"}, int'(state_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, n, dn;
    //          c   a   b  ld2 ld3 en_at len clr  cs  os  dn  err  code  ovf  errcyc
    tbl[0]  = '{3,  0,  8, -1, -1, -1, 0, 1'b0, 1, 1, 1, 1'b0, 2'd0, 1'b0, 0};
    tbl[1]  = '{-1, 0,  1, -1, -1, -1, 0, 1'b0, 1, 0, 0, 1'b1, 2'd1, 1'b0, 2 + T};
    tbl[2]  = '{16, 0,  1, -1, -1, -1, 0, 1'b0, 1, 0, 0, 1'b1, 2'd1, 1'b0, 2 + T};
    tbl[3]  = '{3, -1,  1, -1, -1, -1, 0, 1'b0, 1, 1, 0, 1'b1, 2'd2, 1'b0, 7 + T};
    tbl[4]  = '{3,  0, -1, -1, -1, -1, 0, 1'b0, 1, 1, 0, 1'b1, 2'd3, 1'b0, 8 + T};
    tbl[5]  = '{15, 2,  1, -1, -1, -1, 0, 1'b0, 1, 1, 1, 1'b0, 2'd0, 1'b0, 0};
    tbl[6]  = '{3,  0,  3,  4, -1, -1, 0, 1'b0, NR, NR, NR, 1'b0, 2'd0, !PEND, 0};
    tbl[7]  = '{3,  0,  3,  4,  5, -1, 0, 1'b0, NR, NR, NR, 1'b0, 2'd0, 1'b1, 0};
    tbl[8]  = '{14, 0,  2, -1, -1,  4, 5, 1'b0, 1, 1, 1, 1'b0, 2'd0, 1'b0, 0};
    tbl[9]  = '{-1, 0,  1, -1, -1, -1, 0, 1'b1, 1, 0, 0, 1'b0, 2'd0, 1'b0, 0};
    tbl[10] = '{0,  0,  1, -1, -1, -1, 0, 1'b0, 1, 1, 1, 1'b0, 2'd0, 1'b0, 0};

    repeat (3) @(negedge clk);
    chk_all_zero("in_reset");
    rst_n = 1'b1;
    tick();
    chk_all_zero("after_reset");

    for (int k = 0; k < 11; k++) run_vec(k, tbl[k]);

    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    st = int'(state_o);
    n = 0;
    for (int i = 0; i < 30 && n < 3; i++) begin
      core_valid = (st == 2);
      ol_busy = ol_busy | (st == 4);
      tick();
      st = int'(state_o);
      if (st == 5) n++;
    end
    chk("rst_reach_olwait", n, 3);
    core_valid = 1'b0;
    #2 rst_n = 1'b0;
    rc = 8'd0;
    #1;
    chk_all_zero("mid_reset");
    ol_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      dn += int'(done);
    end
    chk("post_reset_done", dn, 0);
    chk("post_reset_state", int'(state_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
